// File: rtl/pc_seq_unit_if.sv
// Control and status bundle of the program-counter sequencer.
// The master side drives control inputs; the slave side (the sequencer) drives status.
interface pc_seq_unit_if #(
    parameter int D         = 10,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic          stall;
    logic          halt_req;
    logic          branch_en;
    logic          branch_abs;
    logic [D-1:0]  target;
    logic [D-1:0]  absaddress;
    logic          call_en;
    logic          ret_en;
    logic [D-1:0]  prog_ctr;
    logic          halted;
    logic [CW-1:0] ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output stall, halt_req, branch_en, branch_abs, target, absaddress, call_en, ret_en,
        input  prog_ctr, halted, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, halt_req, branch_en, branch_abs, target, absaddress, call_en, ret_en,
        output prog_ctr, halted, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, relative/absolute branch, call/return via a
// circular return-address stack, stall, and an absorbing HALT state.
module pc_seq_unit #(
    parameter int             D          = 10,
    parameter int             RAS_DEPTH  = 4,
    parameter logic [D-1:0]   RESET_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    pc_seq_unit_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [D-1:0]  r_pc;
    logic [D-1:0]  r_ras [RAS_DEPTH];
    logic [PW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    logic          w_run;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_pc_next;
    logic [PW-1:0] w_top_inc;
    logic          w_push;
    logic          w_pop;
    logic          w_unf_set;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == S_RUN && bus.halt_req) w_state_next = S_HALT;
    end

    always_comb begin
        bus.halted = (r_state == S_HALT);
    end

    assign w_run     = (r_state == S_RUN) && !bus.halt_req && !bus.stall;
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_top_inc = r_top + 1'b1;

    // NOTE: every signal assigned below gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_unf_set = 1'b0;
        if (w_run) begin
            if (bus.ret_en) begin
                if (r_count != '0) begin
                    w_pc_next = r_ras[r_top];
                    w_pop     = 1'b1;
                end else begin
                    w_pc_next = w_pc_inc;
                    w_unf_set = 1'b1;
                end
            end else if (bus.call_en) begin
                w_pc_next = bus.absaddress;
                w_push    = 1'b1;
            end else if (bus.branch_en) begin
                // Same-width add wraps modulo 2^D, matching a sign-extended offset.
                w_pc_next = bus.branch_abs ? bus.absaddress : r_pc + bus.target;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_ADDR;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_push) begin
                r_top <= w_top_inc;
                if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + 1'b1;
                else                           r_ovf   <= 1'b1;
            end
            if (w_pop) begin
                r_top   <= r_top - 1'b1;
                r_count <= r_count - 1'b1;
            end
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    // NOTE: stack storage is deliberately not reset; r_count marks which entries are
    // valid, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) r_ras[w_top_inc] <= w_pc_inc;
    end

    assign bus.prog_ctr      = r_pc;
    assign bus.ras_count     = r_count;
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: linear steps with hand-computed expectations.
module tb_pc_seq_unit;
    localparam int D         = 10;
    localparam int RAS_DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_seq_unit_if #(.D(D), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_seq_unit #(.D(D), .RAS_DEPTH(RAS_DEPTH), .RESET_ADDR('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall      = 1'b0;
        bus.halt_req   = 1'b0;
        bus.branch_en  = 1'b0;
        bus.branch_abs = 1'b0;
        bus.target     = '0;
        bus.absaddress = '0;
        bus.call_en    = 1'b0;
        bus.ret_en     = 1'b0;
    endtask

    // Outputs are sampled 1 time unit after the edge that updated them.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic jump_abs(input logic [D-1:0] addr);
        bus.branch_en  = 1'b1;
        bus.branch_abs = 1'b1;
        bus.absaddress = addr;
        tick();
    endtask

    task automatic call(input logic [D-1:0] addr);
        bus.call_en    = 1'b1;
        bus.absaddress = addr;
        tick();
    endtask

    task automatic ret();
        bus.ret_en = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_pc",     bus.prog_ctr, 0);
        check("reset_halted", bus.halted, 0);
        check("reset_count",  bus.ras_count, 0);
        check("reset_ovf",    bus.ras_overflow, 0);
        check("reset_unf",    bus.ras_underflow, 0);

        for (int i = 1; i <= 5; i++) begin
            tick();
            check("idle_inc", bus.prog_ctr, i);
        end

        jump_abs(10'd1023);
        check("abs_1023", bus.prog_ctr, 1023);
        tick();
        check("inc_wrap", bus.prog_ctr, 0);

        jump_abs(10'd20);
        bus.branch_en = 1'b1; bus.target = 10'h3FB;
        tick();
        check("rel_minus5", bus.prog_ctr, 15);
        jump_abs(10'd300);
        check("abs_300", bus.prog_ctr, 300);
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            bus.branch_en = 1'b1; bus.branch_abs = 1'b1; bus.absaddress = 10'd5;
            tick();
            check("stall_hold", bus.prog_ctr, 300);
        end

        jump_abs(10'd2);
        bus.branch_en = 1'b1; bus.target = 10'h3FD;
        tick();
        check("rel_wrap_back", bus.prog_ctr, 1023);
        bus.branch_en = 1'b1; bus.target = 10'd5;
        tick();
        check("rel_wrap_fwd", bus.prog_ctr, 4);

        jump_abs(10'd10);
        call(10'd100);
        check("call_pc",    bus.prog_ctr, 100);
        check("call_count", bus.ras_count, 1);
        ret();
        check("ret_pc",    bus.prog_ctr, 11);
        check("ret_count", bus.ras_count, 0);
        check("ret_unf0",  bus.ras_underflow, 0);
        ret();
        check("unf_pc",   bus.prog_ctr, 12);
        check("unf_flag", bus.ras_underflow, 1);
        check("unf_count", bus.ras_count, 0);

        jump_abs(10'd0);
        call(10'd50);
        call(10'd60);
        call(10'd70);
        check("ovf_clear_at3", bus.ras_overflow, 0);
        call(10'd80);
        check("full_count", bus.ras_count, 4);
        check("ovf_clear_at4", bus.ras_overflow, 0);
        call(10'd90);
        check("ovf_pc",    bus.prog_ctr, 90);
        check("ovf_flag",  bus.ras_overflow, 1);
        check("ovf_count", bus.ras_count, 4);
        ret(); check("ovf_ret1", bus.prog_ctr, 81);
        ret(); check("ovf_ret2", bus.prog_ctr, 71);
        ret(); check("ovf_ret3", bus.prog_ctr, 61);
        ret(); check("ovf_ret4", bus.prog_ctr, 51);
        check("ovf_empty", bus.ras_count, 0);
        check("ovf_sticky", bus.ras_overflow, 1);

        jump_abs(10'd6);
        call(10'd200);
        check("pre_both_count", bus.ras_count, 1);
        bus.call_en = 1'b1; bus.ret_en = 1'b1;
        bus.branch_en = 1'b1; bus.branch_abs = 1'b1; bus.absaddress = 10'd500;
        tick();
        check("both_pc",    bus.prog_ctr, 7);
        check("both_count", bus.ras_count, 0);
        ret();
        check("both_nopush", bus.prog_ctr, 8);

        jump_abs(10'd40);
        bus.halt_req = 1'b1;
        tick();
        check("halt_flag", bus.halted, 1);
        check("halt_pc",   bus.prog_ctr, 40);
        bus.branch_en = 1'b1; bus.branch_abs = 1'b1; bus.absaddress = 10'd99;
        tick();
        check("halt_branch", bus.prog_ctr, 40);
        call(10'd123);
        check("halt_call_pc",    bus.prog_ctr, 40);
        check("halt_call_count", bus.ras_count, 0);
        tick();
        check("halt_idle", bus.prog_ctr, 40);
        check("halt_stays", bus.halted, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_pc",     bus.prog_ctr, 0);
        check("rst2_halted", bus.halted, 0);
        check("rst2_ovf",    bus.ras_overflow, 0);
        check("rst2_unf",    bus.ras_underflow, 0);
        tick();
        check("rst2_inc", bus.prog_ctr, 1);

        bus.stall = 1'b1; bus.halt_req = 1'b1;
        tick();
        check("stall_halt_flag", bus.halted, 1);
        check("stall_halt_pc",   bus.prog_ctr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the single-cycle core. It replaces the plain increment/jump counter.
- Adds relative and absolute branches, call/return through an internal return-address stack (RAS), pipeline stall, and a halt state machine.
- Sits at the head of the fetch path. `prog_ctr` drives instruction-memory address.

Parameters:
- D, 10, address width; `prog_ctr`, `target` and `absaddress` are D bits.
- RAS_DEPTH, 4, number of return-address stack entries (>=2, power of two).
- RESET_ADDR, 0, value loaded into `prog_ctr` on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- halt_req  input  1  enter HALT state.
- branch_en  input  1  take a branch this cycle.
- branch_abs  input  1  with `branch_en`: 1 = absolute (`absaddress`), 0 = relative (`target`).
- target  input  D  signed two's-complement relative offset.
- absaddress  input  D  absolute branch/call destination.
- call_en  input  1  push return address, jump to `absaddress`.
- ret_en  input  1  pop RAS into `prog_ctr`.
- prog_ctr  output  D  current fetch address.
- halted  output  1  high in HALT state.
- ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_overflow  output  1  sticky: a call occurred with RAS full.
- ras_underflow  output  1  sticky: a return occurred with RAS empty.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - `prog_ctr` = RESET_ADDR; state = RUN; `halted` = 0.
  - `ras_count` = 0; `ras_overflow` = 0; `ras_underflow` = 0; RAS contents don't-care.
- States: RUN, HALT.
  - RUN -> HALT when `halt_req` = 1 (also while `stall` = 1); `prog_ctr` holds that cycle.
  - HALT is absorbing: only reset leaves it. All other inputs are ignored and all outputs hold.
- In RUN with `halt_req` = 0, the update priority per cycle is:
  - `stall`: everything holds, including RAS and flags.
  - `ret_en`:
    - If `ras_count` > 0: `prog_ctr` <= top entry, `ras_count`--.
    - If `ras_count` = 0: `prog_ctr` <= `prog_ctr`+1 and set `ras_underflow`.
  - `call_en`: push `prog_ctr`+1, `prog_ctr` <= `absaddress`.
    - If RAS is full: the push overwrites the oldest entry (circular), `ras_count` stays RAS_DEPTH, and `ras_overflow` is set.
  - `branch_en` && `branch_abs`: `prog_ctr` <= `absaddress`.
  - `branch_en` && !`branch_abs`: `prog_ctr` <= `prog_ctr` + `target`, with `target` sign-extended and the result modulo 2^D (wraps both directions).
  - Otherwise: `prog_ctr` <= `prog_ctr`+1, modulo 2^D (all-ones wraps to 0).
- Simultaneous `call_en` and `ret_en`: return wins and the call is dropped. A lower-priority `branch_en` in the same cycle is ignored.
- Return-address computation `prog_ctr`+1 wraps modulo 2^D.
- Latency: the new `prog_ctr` is visible one cycle after the control inputs are sampled. There are no combinational paths from inputs to outputs.
- RAS is a circular buffer with a top pointer. Pop after an overflow returns the most recent RAS_DEPTH addresses in LIFO order.
- Sticky flags clear only on reset.

Test Plan:
- Reset, then 5 idle cycles -> `prog_ctr` 0,1,2,3,4,5. Force `prog_ctr` to 1023 (D=10) and idle -> next is 0.
- At `prog_ctr`=20: relative branch `target`=10'h3FB (-5) -> 15. Then absolute branch `absaddress`=300 -> 300. `stall` held 3 cycles -> stays 300.
- `call_en` at `prog_ctr`=10 with `absaddress`=100 -> 100, `ras_count`=1. `ret_en` -> 11, `ras_count`=0. A second `ret_en` -> 12 with `ras_underflow`=1.
- 5 calls at `prog_ctr` 0,50,60,70,80 (RAS_DEPTH=4) -> `ras_overflow`=1, `ras_count`=4. 4 returns -> 81,71,61,51.
- `call_en` and `ret_en` together with `ras_count`=1 (top=7) -> `prog_ctr`=7, `ras_count`=0, no push.
- `halt_req` at `prog_ctr`=40 -> `halted`=1, `prog_ctr` stays 40 under later branch/call. `reset` mid-halt -> `prog_ctr`=0, `halted`=0, flags cleared.
